riscv_mc_controller: RTL and testbench

Multicycle control unit for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives datapath mux selects, write strobes and the 3-bit ALU control code, using the same encoding the ALU consumes. It also takes the ALU zero flag back for branch resolution, and stalls on a memory-ready handshake so the datapath can share one memory port for instructions and data.

---
 rtl/riscv_mc_controller.sv | 208 ++++++++++++++++++++
 tb/tb_riscv_mc_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multicycle control unit for the RV32I core.
// Sequences each instruction through fetch / decode / execute / memory /
// writeback, drives the datapath selects, write strobes and ALU control, and
// stalls in FETCH, MEMREAD and MEMWRITE until the shared memory port is ready.
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN. When defined, an unknown
// opcode halts the core in ILLEGAL and raises the sticky o_illegal flag.
// Otherwise an unknown opcode behaves as a two-cycle NOP and o_illegal is 0.
module riscv_mc_controller (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_adr_src,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic       o_reg_write,
    output logic [1:0] o_imm_src,
    output logic [2:0] o_alu_ctrl,
    output logic       o_illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
    } state_t;
`else
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
    } state_t;
`endif

    state_t     state;
    state_t     next_state;
    logic [2:0] funct_ctrl;
    logic       pc_write_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;

    // State register: synchronous reset returns the sequencer to FETCH.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (i_rst) state <= S_FETCH;
        else       state <= next_state;
    end

    // Next-state logic: stall states wait on i_mem_ready, DECODE dispatches on opcode.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            S_FETCH:    if (i_mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (i_op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:      next_state = S_ILLEGAL;
`else
                    default:      next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   next_state = (i_op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (i_mem_ready) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (i_mem_ready) next_state = S_FETCH;
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_ILLEGAL:  next_state = S_ILLEGAL;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (i_op)
            OP_LW, OP_I: o_imm_src = 2'b00;
            OP_SW:       o_imm_src = 2'b01;
            OP_BEQ:      o_imm_src = 2'b10;
            OP_JAL:      o_imm_src = 2'b11;
            default:     o_imm_src = 2'b00;
        endcase
    end

    // ALU operation from funct fields; funct7b5 selects SUB only for R-type.
    always_comb begin
        case (i_funct3)
            3'b000:  funct_ctrl = (i_op == OP_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctrl = ALU_SLT;
            3'b110:  funct_ctrl = ALU_OR;
            3'b111:  funct_ctrl = ALU_AND;
            default: funct_ctrl = ALU_ADD;
        endcase
    end

    // Output logic: selects and raw strobes per state; unlisted signals stay 0.
    always_comb begin
        pc_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        o_adr_src    = 1'b0;
        o_result_src = 2'b00;
        o_alu_src_a  = 2'b00;
        o_alu_src_b  = 2'b00;
        o_alu_ctrl   = ALU_ADD;
        case (state)
            S_FETCH: begin
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                ir_write_s   = i_mem_ready;
                pc_write_s   = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
            end
            S_MEMREAD:  o_adr_src = 1'b1;
            S_MEMWB: begin
                o_result_src = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                o_adr_src   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                o_alu_src_a = 2'b10;
                o_alu_ctrl  = funct_ctrl;
            end
            S_EXECI: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
                o_alu_ctrl  = funct_ctrl;
            end
            S_ALUWB:    reg_write_s = 1'b1;
            S_BEQ: begin
                o_alu_src_a = 2'b10;
                o_alu_ctrl  = ALU_SUB;
                pc_write_s  = i_zero;
            end
            S_JAL: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b10;
                pc_write_s  = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset suppresses every architectural write in the cycle it is asserted.
    assign o_pc_write  = pc_write_s  & ~i_rst;
    assign o_ir_write  = ir_write_s  & ~i_rst;
    assign o_reg_write = reg_write_s & ~i_rst;
    assign o_mem_write = mem_write_s & ~i_rst;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky flag set on the same edge that enters ILLEGAL; cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst)                       illegal_q <= 1'b0;
        else if (next_state == S_ILLEGAL) illegal_q <= 1'b1;
    end

    assign o_illegal = illegal_q;
`else
    assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Testbench for riscv_mc_controller: table-driven vectors, hand-written
// multi-cycle sequences, and randomized instructions checked against a
// per-instruction phase list model. Honors MC_CTRL_ILLEGAL_TRAP_EN.
module tb_riscv_mc_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_UNK = 7'b1111111;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic [1:0] imm_src;
        logic [2:0] alu_ctrl;
        logic       illegal;
    } out_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        logic       rdy;
        out_t       exp;
        string      name;
    } vec_t;

    typedef struct {
        out_t  o;
        bit    waits;
        bit    is_fetch;
        string name;
    } phase_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = OP_R;
    logic [2:0] f3 = 3'b000;
    logic       f7 = 1'b0;
    logic       zero = 1'b0;
    logic       rdy = 1'b0;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_ctrl;
    out_t       got;

    int errors = 0;
    int checks = 0;

    vec_t   vecs[$];
    phase_t phases[$];

    always #5 clk = ~clk;

    riscv_mc_controller dut (
        .i_clk(clk), .i_rst(rst), .i_op(op), .i_funct3(f3), .i_funct7b5(f7),
        .i_zero(zero), .i_mem_ready(rdy),
        .o_pc_write(pc_write), .o_adr_src(adr_src), .o_mem_write(mem_write),
        .o_ir_write(ir_write), .o_result_src(result_src), .o_alu_src_a(alu_src_a),
        .o_alu_src_b(alu_src_b), .o_reg_write(reg_write), .o_imm_src(imm_src),
        .o_alu_ctrl(alu_ctrl), .o_illegal(illegal)
    );

    assign got = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, reg_write, imm_src, alu_ctrl, illegal};

    // ---------------- reference model: expected outputs per phase ----------------
    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] funct_of(input logic [6:0] o, input logic [2:0] f, input logic b5);
        if (f == 3'b000) return (o == OP_R && b5) ? 3'b001 : 3'b000;
        if (f == 3'b010) return 3'b101;
        if (f == 3'b110) return 3'b011;
        if (f == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic out_t base(input logic [6:0] o);
        out_t r = '0;
        r.imm_src = imm_of(o);
        return r;
    endfunction

    function automatic out_t o_fetch(input logic [6:0] o, input logic r_in);
        out_t r = base(o);
        r.alu_src_b = 2'b10; r.result_src = 2'b10;
        r.ir_write = r_in;   r.pc_write = r_in;
        return r;
    endfunction

    function automatic out_t o_decode(input logic [6:0] o);
        out_t r = base(o);
        r.alu_src_a = 2'b01; r.alu_src_b = 2'b01;
        return r;
    endfunction

    function automatic out_t o_memadr(input logic [6:0] o);
        out_t r = base(o);
        r.alu_src_a = 2'b10; r.alu_src_b = 2'b01;
        return r;
    endfunction

    function automatic out_t o_memread(input logic [6:0] o);
        out_t r = base(o);
        r.adr_src = 1'b1;
        return r;
    endfunction

    function automatic out_t o_memwb(input logic [6:0] o);
        out_t r = base(o);
        r.result_src = 2'b01; r.reg_write = 1'b1;
        return r;
    endfunction

    function automatic out_t o_memwrite(input logic [6:0] o);
        out_t r = base(o);
        r.adr_src = 1'b1; r.mem_write = 1'b1;
        return r;
    endfunction

    function automatic out_t o_exec(input logic [6:0] o, input logic [2:0] f, input logic b5, input bit imm);
        out_t r = base(o);
        r.alu_src_a = 2'b10; r.alu_src_b = imm ? 2'b01 : 2'b00;
        r.alu_ctrl  = funct_of(o, f, b5);
        return r;
    endfunction

    function automatic out_t o_aluwb(input logic [6:0] o);
        out_t r = base(o);
        r.reg_write = 1'b1;
        return r;
    endfunction

    function automatic out_t o_beq(input logic [6:0] o, input logic z);
        out_t r = base(o);
        r.alu_src_a = 2'b10; r.alu_ctrl = 3'b001; r.pc_write = z;
        return r;
    endfunction

    function automatic out_t o_jal(input logic [6:0] o);
        out_t r = base(o);
        r.alu_src_a = 2'b01; r.alu_src_b = 2'b10; r.pc_write = 1'b1;
        return r;
    endfunction

    function automatic out_t o_halted(input logic [6:0] o);
        out_t r = base(o);
        r.illegal = 1'b1;
        return r;
    endfunction

    // Instruction = ordered list of phases; stall phases repeat while not ready.
    function automatic void add_phase(input out_t o, input bit w, input bit f, input string n);
        phase_t p;
        p.o = o; p.waits = w; p.is_fetch = f; p.name = n;
        phases.push_back(p);
    endfunction

    function automatic void build(input logic [6:0] o, input logic [2:0] f, input logic b5, input logic z);
        phases.delete();
        add_phase(o_fetch(o, 1'b1), 1, 1, "rnd fetch");
        add_phase(o_decode(o), 0, 0, "rnd decode");
        case (o)
            OP_LW: begin
                add_phase(o_memadr(o), 0, 0, "rnd lw memadr");
                add_phase(o_memread(o), 1, 0, "rnd lw memread");
                add_phase(o_memwb(o), 0, 0, "rnd lw memwb");
            end
            OP_SW: begin
                add_phase(o_memadr(o), 0, 0, "rnd sw memadr");
                add_phase(o_memwrite(o), 1, 0, "rnd sw memwrite");
            end
            OP_R: begin
                add_phase(o_exec(o, f, b5, 0), 0, 0, "rnd r exec");
                add_phase(o_aluwb(o), 0, 0, "rnd r wb");
            end
            OP_I: begin
                add_phase(o_exec(o, f, b5, 1), 0, 0, "rnd i exec");
                add_phase(o_aluwb(o), 0, 0, "rnd i wb");
            end
            OP_BEQ: add_phase(o_beq(o, z), 0, 0, "rnd beq");
            OP_JAL: begin
                add_phase(o_jal(o), 0, 0, "rnd jal");
                add_phase(o_aluwb(o), 0, 0, "rnd jal wb");
            end
            default: ;
        endcase
    endfunction

    function automatic void add_vec(input logic r_in, input logic [6:0] o, input logic [2:0] f,
                                    input logic b5, input logic z, input logic rd,
                                    input out_t e, input string n);
        vec_t v;
        v.rst = r_in; v.op = o; v.f3 = f; v.f7 = b5; v.zero = z; v.rdy = rd; v.exp = e; v.name = n;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, compare outputs mid-cycle, advance past the edge.
    task automatic apply(input logic r_in, input logic [6:0] o, input logic [2:0] f,
                         input logic b5, input logic z, input logic rd,
                         input out_t e, input string n);
        rst = r_in; op = o; f3 = f; f7 = b5; zero = z; rdy = rd;
        @(negedge clk);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got=%05h expected=%05h (pcw adr memw irw res[2] a[2] b[2] regw imm[2] alu[3] ill)",
                     n, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] rop;
        logic [2:0] rf3;
        logic       rf7, rz, rrd;
        int         stalls;
        out_t       e;

        // Table: reset masking, R/I-type decode, beq taken/not taken, jal.
        add_vec(1, OP_R, 3'b000, 1, 0, 1, o_fetch(OP_R, 0), "reset masks strobes");
        add_vec(0, OP_R, 3'b000, 1, 0, 1, o_fetch(OP_R, 1), "sub fetch");
        add_vec(0, OP_R, 3'b000, 1, 0, 1, o_decode(OP_R), "sub decode");
        add_vec(0, OP_R, 3'b000, 1, 0, 1, o_exec(OP_R, 3'b000, 1, 0), "sub execr");
        add_vec(0, OP_R, 3'b000, 1, 0, 1, o_aluwb(OP_R), "sub aluwb");
        add_vec(0, OP_I, 3'b010, 0, 0, 1, o_fetch(OP_I, 1), "slti fetch");
        add_vec(0, OP_I, 3'b010, 0, 0, 1, o_decode(OP_I), "slti decode");
        add_vec(0, OP_I, 3'b010, 0, 0, 1, o_exec(OP_I, 3'b010, 0, 1), "slti execi");
        add_vec(0, OP_I, 3'b010, 0, 0, 1, o_aluwb(OP_I), "slti aluwb");
        add_vec(0, OP_I, 3'b000, 1, 0, 1, o_fetch(OP_I, 1), "addi fetch");
        add_vec(0, OP_I, 3'b000, 1, 0, 1, o_decode(OP_I), "addi decode");
        add_vec(0, OP_I, 3'b000, 1, 0, 1, o_exec(OP_I, 3'b000, 1, 1), "addi b5 ignored");
        add_vec(0, OP_I, 3'b000, 1, 0, 1, o_aluwb(OP_I), "addi aluwb");
        add_vec(0, OP_BEQ, 3'b000, 0, 1, 1, o_fetch(OP_BEQ, 1), "beq1 fetch");
        add_vec(0, OP_BEQ, 3'b000, 0, 1, 1, o_decode(OP_BEQ), "beq1 decode");
        add_vec(0, OP_BEQ, 3'b000, 0, 1, 0, o_beq(OP_BEQ, 1), "beq taken");
        add_vec(0, OP_BEQ, 3'b000, 0, 0, 1, o_fetch(OP_BEQ, 1), "beq2 fetch");
        add_vec(0, OP_BEQ, 3'b000, 0, 0, 1, o_decode(OP_BEQ), "beq2 decode");
        add_vec(0, OP_BEQ, 3'b000, 0, 0, 1, o_beq(OP_BEQ, 0), "beq not taken");
        add_vec(0, OP_JAL, 3'b000, 0, 0, 1, o_fetch(OP_JAL, 1), "jal fetch");
        add_vec(0, OP_JAL, 3'b000, 0, 0, 1, o_decode(OP_JAL), "jal decode");
        add_vec(0, OP_JAL, 3'b000, 0, 0, 1, o_jal(OP_JAL), "jal pc write");
        add_vec(0, OP_JAL, 3'b000, 0, 0, 1, o_aluwb(OP_JAL), "jal aluwb");
        add_vec(0, OP_R, 3'b111, 0, 0, 0, o_fetch(OP_R, 0), "jal back to fetch");

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i])
            apply(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zero,
                  vecs[i].rdy, vecs[i].exp, vecs[i].name);

        // lw with two wait states in MEMREAD: seven cycles, then FETCH.
        apply(0, OP_LW, 3'b010, 0, 0, 1, o_fetch(OP_LW, 1), "lw fetch");
        apply(0, OP_LW, 3'b010, 0, 0, 0, o_decode(OP_LW), "lw decode");
        apply(0, OP_LW, 3'b010, 0, 0, 0, o_memadr(OP_LW), "lw memadr");
        apply(0, OP_LW, 3'b010, 0, 0, 0, o_memread(OP_LW), "lw stall 1");
        apply(0, OP_LW, 3'b010, 0, 0, 0, o_memread(OP_LW), "lw stall 2");
        apply(0, OP_LW, 3'b010, 0, 0, 1, o_memread(OP_LW), "lw memread ready");
        apply(0, OP_LW, 3'b010, 0, 0, 0, o_memwb(OP_LW), "lw memwb");
        apply(0, OP_R, 3'b000, 0, 0, 0, o_fetch(OP_R, 0), "lw back to fetch");

        // sw with three wait states in FETCH; mem_write for exactly one cycle.
        for (int i = 0; i < 3; i++)
            apply(0, OP_SW, 3'b010, 0, 0, 0, o_fetch(OP_SW, 0), "sw fetch stall");
        apply(0, OP_SW, 3'b010, 0, 0, 1, o_fetch(OP_SW, 1), "sw fetch ready");
        apply(0, OP_SW, 3'b010, 0, 0, 0, o_decode(OP_SW), "sw decode");
        apply(0, OP_SW, 3'b010, 0, 0, 0, o_memadr(OP_SW), "sw memadr");
        apply(0, OP_SW, 3'b010, 0, 0, 1, o_memwrite(OP_SW), "sw memwrite");
        apply(0, OP_SW, 3'b010, 0, 0, 0, o_fetch(OP_SW, 0), "sw single strobe");

        // Reset during a MEMWRITE stall aborts without a write strobe.
        apply(0, OP_SW, 3'b010, 0, 0, 1, o_fetch(OP_SW, 1), "abort fetch");
        apply(0, OP_SW, 3'b010, 0, 0, 1, o_decode(OP_SW), "abort decode");
        apply(0, OP_SW, 3'b010, 0, 0, 1, o_memadr(OP_SW), "abort memadr");
        apply(0, OP_SW, 3'b010, 0, 0, 0, o_memwrite(OP_SW), "abort memwrite stall");
        e = o_memwrite(OP_SW);
        e.mem_write = 1'b0;
        apply(1, OP_SW, 3'b010, 0, 0, 0, e, "reset kills mem_write");
        apply(0, OP_R, 3'b000, 0, 0, 0, o_fetch(OP_R, 0), "abort back to fetch");

        // Unknown opcode.
        apply(0, OP_UNK, 3'b000, 0, 0, 1, o_fetch(OP_UNK, 1), "unk fetch");
        apply(0, OP_UNK, 3'b000, 0, 0, 1, o_decode(OP_UNK), "unk decode");
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++)
            apply(0, OP_UNK, 3'b000, 0, 1, 1, o_halted(OP_UNK), "illegal halted");
        apply(1, OP_UNK, 3'b000, 0, 1, 1, o_halted(OP_UNK), "illegal during reset");
        apply(0, OP_R, 3'b000, 0, 0, 0, o_fetch(OP_R, 0), "illegal cleared");
`else
        apply(0, OP_R, 3'b000, 0, 0, 0, o_fetch(OP_R, 0), "unk nop back to fetch");
`endif

        // Randomized instruction stream against the phase-list model.
        for (int n = 0; n < 250; n++) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            case ($urandom_range(0, 5))
`else
            case ($urandom_range(0, 7))
`endif
                0: rop = OP_LW;
                1: rop = OP_SW;
                2: rop = OP_R;
                3: rop = OP_I;
                4: rop = OP_BEQ;
                5: rop = OP_JAL;
                6: rop = OP_UNK;
                default: rop = 7'b0110111;
            endcase
            rf3 = 3'($urandom);
            rf7 = 1'($urandom);
            rz  = 1'($urandom);
            build(rop, rf3, rf7, rz);
            foreach (phases[p]) begin
                stalls = 0;
                do begin
                    if (phases[p].waits)
                        rrd = (stalls >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    else
                        rrd = 1'($urandom);
                    e = phases[p].o;
                    if (phases[p].is_fetch) begin
                        e.ir_write = rrd;
                        e.pc_write = rrd;
                    end
                    apply(0, rop, rf3, rf7, rz, rrd, e, phases[p].name);
                    stalls++;
                end while (phases[p].waits && !rrd);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
